// File: rtl/ludh_seq_pkg.sv
// ludh_seq_pkg: shared state encoding and constants for the LU instruction sequencer
package ludh_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RUN = 2'd2, DONE = 2'd3} seq_state_t;
  localparam int SEQ_CTRL_WIDTH = 60;
  localparam logic [SEQ_CTRL_WIDTH-1:0] SEQ_END_WORD = '1;
  localparam int SEQ_RUN_CYCLES_WIDTH = 32;
endpackage

// File: rtl/ludh_inst_port_mux.sv
// ludh_inst_port_mux: instruction BRAM port owner select and host-collision detect
module ludh_inst_port_mux #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  host_lock,
  input  logic [ADDR_WIDTH-1:0] seq_addr,
  input  logic                  seq_en,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_en,
  input  logic                  host_we,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_en,
  output logic                  inst_we,
  output logic                  conflict
);
  always_comb begin
    inst_addr = host_lock ? seq_addr : host_addr;
    inst_en = host_lock ? seq_en : host_en;
    inst_we = host_lock ? 1'b0 : host_we;
    conflict = host_lock && host_en;
  end
endmodule

// File: rtl/ludh_inst_sequencer.sv
// ludh_inst_sequencer: streams BRAM control words to the datapath and arbitrates the BRAM port.
// Define LUDH_SEQ_CYCLE_COUNT_EN to enable the saturating run_cycles counter.
module ludh_inst_sequencer
  import ludh_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CTRL_WIDTH = SEQ_CTRL_WIDTH
) (
  input  logic                            CLK_100,
  input  logic                            RST_IN,
  input  logic                            locked,
  input  logic                            START,
  output logic                            COMPLETED,
  output logic                            overrun,
  input  logic                            stall,
  output logic [CTRL_WIDTH-1:0]           ctrl_signal,
  input  logic [ADDR_WIDTH-1:0]           host_addr,
  input  logic                            host_en,
  input  logic                            host_we,
  output logic                            host_conflict,
  output logic                            host_lock,
  output logic [ADDR_WIDTH-1:0]           inst_addr,
  output logic                            inst_en,
  output logic                            inst_we,
  input  logic [CTRL_WIDTH-1:0]           inst_dout,
  output logic [SEQ_RUN_CYCLES_WIDTH-1:0] run_cycles,
  output logic [1:0]                      debug_state
);
  seq_state_t state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic last, drain, start_q, armed, conflict;
  logic rst_n, start_edge, is_end;
  assign rst_n = RST_IN && locked;
  // armed blocks a START that was already high when reset released
  assign start_edge = START && !start_q && armed;
  assign is_end = &inst_dout;
  assign host_lock = state == FETCH || state == RUN;
  assign debug_state = state;
  ludh_inst_port_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_port_mux (
    .host_lock(host_lock),
    .seq_addr(ptr),
    .seq_en(!stall && !last),
    .host_addr(host_addr),
    .host_en(host_en),
    .host_we(host_we),
    .inst_addr(inst_addr),
    .inst_en(inst_en),
    .inst_we(inst_we),
    .conflict(conflict)
  );
  always_ff @(posedge CLK_100) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      last <= 1'b0;
      drain <= 1'b0;
      start_q <= 1'b0;
      armed <= !START;
      ctrl_signal <= '0;
      COMPLETED <= 1'b0;
      overrun <= 1'b0;
      host_conflict <= 1'b0;
    end else begin
      start_q <= START;
      armed <= armed || !START;
      host_conflict <= host_conflict || conflict;
      ctrl_signal <= '0;
      case (state)
        IDLE, DONE: if (start_edge) begin
          state <= FETCH;
          ptr <= '0;
          last <= 1'b0;
          drain <= 1'b0;
          COMPLETED <= 1'b0;
          overrun <= 1'b0;
          host_conflict <= 1'b0;
        end
        FETCH: if (!stall) begin
          ptr <= ADDR_WIDTH'(1);
          state <= RUN;
        end
        RUN: if (drain) begin
          // final word of an exhausted address space was emitted last cycle
          state <= DONE;
          COMPLETED <= 1'b1;
          overrun <= 1'b1;
        end else if (!stall) begin
          if (is_end) begin
            state <= DONE;
            COMPLETED <= 1'b1;
          end else begin
            ctrl_signal <= inst_dout;
            ptr <= ptr + 1'b1;
            last <= last || &ptr;
            drain <= last;
          end
        end
      endcase
    end
  end
`ifdef LUDH_SEQ_CYCLE_COUNT_EN
  logic [SEQ_RUN_CYCLES_WIDTH-1:0] run_cnt;
  always_ff @(posedge CLK_100) begin
    if (!rst_n) run_cnt <= '0;
    else if (!host_lock && start_edge) run_cnt <= '0;
    else if (host_lock && run_cnt != '1) run_cnt <= run_cnt + 1'b1;
  end
  assign run_cycles = run_cnt;
`else
  assign run_cycles = '0;
`endif
endmodule
